// File: rtl/add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package add_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StAdd  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Nibble counter width; a single-nibble adder still keeps a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/add_seq_nib_if.sv
// Start/done handshake and operand/result bundle for add_seq_nib.
interface add_seq_nib_if
  import add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) ();

  localparam int unsigned W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, A, B, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, A, B, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/adder_4b.sv
// Combinational 4-bit adder slice with carry in and carry out.
module adder_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/add_seq_nib.sv
// Multi-cycle adder: one nibble per cycle through a shared 4-bit slice, carry held
// in a register between slices.
module add_seq_nib
  import add_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input logic         clk,
  input logic         rst,
  add_seq_nib_if.slave bus
);

  localparam int unsigned W    = NIBBLE_W * NIBBLES;
  localparam int unsigned CntW = cnt_width(NIBBLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(NIBBLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  assign slice_a = a_q[NIBBLE_W*cnt_q +: NIBBLE_W];
  assign slice_b = b_q[NIBBLE_W*cnt_q +: NIBBLE_W];

  adder_4b u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.cin;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StAdd;
          end
        end
        StAdd: begin
          sum_q[NIBBLE_W*cnt_q +: NIBBLE_W] <= slice_sum;
          carry_q <= slice_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            cout_q  <= slice_cout;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          // start is deliberately not sampled here; it must be re-presented in idle.
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
